// File: rtl/clk_en_multi.sv
// Multi-channel programmable clock-enable generator: per-channel divider,
// continuous/one-shot mode, boundary-aligned config updates, wrapping tick counters.
module clk_en_multi #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_wr,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [1:0]            cfg_mode,
  input  logic                  sync,
  input  logic [N_CH-1:0]       cnt_clr,
  output logic [N_CH-1:0]       clk_en,
  output logic [N_CH-1:0]       cfg_pend,
  output logic [N_CH*CNT_W-1:0] tick_cnt
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_CONT    = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_e;

  mode_e            mode_q  [N_CH];
  mode_e            mode_d  [N_CH];
  mode_e            pmode_q [N_CH];
  mode_e            pmode_d [N_CH];
  logic [DIV_W-1:0] div_q   [N_CH];
  logic [DIV_W-1:0] div_d   [N_CH];
  logic [DIV_W-1:0] pdiv_q  [N_CH];
  logic [DIV_W-1:0] pdiv_d  [N_CH];
  logic [DIV_W-1:0] cntr_q  [N_CH];
  logic [DIV_W-1:0] cntr_d  [N_CH];
  logic [CNT_W-1:0] tick_q  [N_CH];
  logic [CNT_W-1:0] tick_d  [N_CH];
  logic [N_CH-1:0]  pend_q;
  logic [N_CH-1:0]  pend_d;
  logic [N_CH-1:0]  term;
  logic [N_CH-1:0]  hit;
  mode_e            wmode;

  always_comb begin
    unique case (cfg_mode)
      2'b01:   wmode = MODE_CONT;
      2'b10:   wmode = MODE_ONESHOT;
      default: wmode = MODE_OFF;
    endcase
  end

  // sync is the only input reaching clk_en, and only as a suppression gate
  always_comb begin
    term     = '0;
    hit      = '0;
    clk_en   = '0;
    cfg_pend = pend_q;
    tick_cnt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      term[i]   = (mode_q[i] != MODE_OFF) && (cntr_q[i] == div_q[i]);
      hit[i]    = cfg_wr && (32'(cfg_ch) == i);
      clk_en[i] = term[i] && !sync;
      tick_cnt[i*CNT_W +: CNT_W] = tick_q[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      mode_d[i]  = mode_q[i];
      pmode_d[i] = pmode_q[i];
      div_d[i]   = div_q[i];
      pdiv_d[i]  = pdiv_q[i];
      cntr_d[i]  = cntr_q[i];
      pend_d[i]  = pend_q[i];
      tick_d[i]  = tick_q[i];

      if (sync) begin
        cntr_d[i] = '0;
        pend_d[i] = 1'b0;
        if (hit[i]) begin
          mode_d[i] = wmode;
          div_d[i]  = cfg_div;
        end else if (pend_q[i]) begin
          mode_d[i] = pmode_q[i];
          div_d[i]  = pdiv_q[i];
        end
      end else if (hit[i] && wmode == MODE_OFF) begin
        mode_d[i] = MODE_OFF;
        cntr_d[i] = '0;
        pend_d[i] = 1'b0;
      end else if (hit[i] && (mode_q[i] == MODE_OFF || term[i])) begin
        mode_d[i] = wmode;
        div_d[i]  = cfg_div;
        cntr_d[i] = '0;
        pend_d[i] = 1'b0;
      end else if (hit[i]) begin
        pmode_d[i] = wmode;
        pdiv_d[i]  = cfg_div;
        pend_d[i]  = 1'b1;
        cntr_d[i]  = cntr_q[i] + DIV_W'(1);
      end else if (term[i]) begin
        cntr_d[i] = '0;
        pend_d[i] = 1'b0;
        if (pend_q[i]) begin
          mode_d[i] = pmode_q[i];
          div_d[i]  = pdiv_q[i];
        end else if (mode_q[i] == MODE_ONESHOT) begin
          mode_d[i] = MODE_OFF;
        end
      end else if (mode_q[i] != MODE_OFF) begin
        cntr_d[i] = cntr_q[i] + DIV_W'(1);
      end

      if (cnt_clr[i]) begin
        tick_d[i] = '0;
      end else if (clk_en[i]) begin
        tick_d[i] = tick_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        mode_q[i]  <= MODE_OFF;
        pmode_q[i] <= MODE_OFF;
        div_q[i]   <= '0;
        pdiv_q[i]  <= '0;
        cntr_q[i]  <= '0;
        tick_q[i]  <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        mode_q[i]  <= mode_d[i];
        pmode_q[i] <= pmode_d[i];
        div_q[i]   <= div_d[i];
        pdiv_q[i]  <= pdiv_d[i];
        cntr_q[i]  <= cntr_d[i];
        tick_q[i]  <= tick_d[i];
      end
    end
  end

endmodule

// File: tb/tb_clk_en_multi.sv
// Scoreboard bench for clk_en_multi: a countdown-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_clk_en_multi;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_wr = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [DW-1:0]     cfg_div = '0;
  logic [1:0]        cfg_mode = '0;
  logic              sync = 1'b0;
  logic [NCH-1:0]    cnt_clr = '0;
  logic [NCH-1:0]    clk_en;
  logic [NCH-1:0]    cfg_pend;
  logic [NCH*CW-1:0] tick_cnt;

  clk_en_multi #(.N_CH(NCH), .DIV_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .sync(sync), .cnt_clr(cnt_clr),
    .clk_en(clk_en), .cfg_pend(cfg_pend), .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    pend;
    logic [NCH*CW-1:0] tick;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: each channel counts down the cycles left until its strobe
  bit m_on [NCH];
  bit m_os [NCH];
  int m_div[NCH];
  int m_rem[NCH];
  bit m_pend[NCH];
  int m_pdiv[NCH];
  int m_pmode[NCH];
  int m_tick[NCH];

  function automatic void m_apply(input int c, input int md, input int dv);
    m_on[c]  = (md == 1) || (md == 2);
    m_os[c]  = (md == 2);
    m_div[c] = dv;
    m_rem[c] = dv;
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_on[c] = 0; m_os[c] = 0; m_div[c] = 0; m_rem[c] = 0;
      m_pend[c] = 0; m_pdiv[c] = 0; m_pmode[c] = 0; m_tick[c] = 0;
    end
  endfunction

  task automatic step(input bit wr, input int ch, input int dv, input int md,
                      input bit sy, input bit [NCH-1:0] clr, input bit rst, input bit chk);
    exp_t e;
    bit   strobe [NCH];
    bit   hit;
    @(posedge clk);
    #1;
    reset = rst; cfg_wr = wr; cfg_ch = 2'(ch); cfg_div = DW'(dv);
    cfg_mode = 2'(md); sync = sy; cnt_clr = clr;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      strobe[c]   = m_on[c] && (m_rem[c] == 0) && !sy;
      e.en[c]     = strobe[c];
      e.pend[c]   = m_pend[c];
      e.tick[c*CW +: CW] = CW'(m_tick[c]);
    end
    if (chk) sb.push_back(e);
    if (rst) begin
      m_reset();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        hit = wr && (ch == c);
        if (sy) begin
          if (hit) m_apply(c, md, dv);
          else if (m_pend[c]) m_apply(c, m_pmode[c], m_pdiv[c]);
          else m_rem[c] = m_div[c];
          m_pend[c] = 0;
        end else if (hit && !((md == 1) || (md == 2))) begin
          m_on[c] = 0; m_pend[c] = 0;
        end else if (hit && (!m_on[c] || strobe[c])) begin
          m_apply(c, md, dv); m_pend[c] = 0;
        end else if (hit) begin
          m_pend[c] = 1; m_pdiv[c] = dv; m_pmode[c] = md; m_rem[c]--;
        end else if (m_on[c]) begin
          if (strobe[c]) begin
            if (m_pend[c]) begin
              m_apply(c, m_pmode[c], m_pdiv[c]); m_pend[c] = 0;
            end else if (m_os[c]) m_on[c] = 0;
            else m_rem[c] = m_div[c];
          end else m_rem[c]--;
        end
        if (clr[c]) m_tick[c] = 0;
        else if (strobe[c]) m_tick[c] = (m_tick[c] + 1) % (1 << CW);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, '0, 0, 1);
  endtask

  task automatic wrc(input int ch, input int dv, input int md);
    step(1, ch, dv, md, 0, '0, 0, 1);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (clk_en !== e.en) begin
        n_fail++;
        $display("FAIL clk_en cyc=%0d got=%b exp=%b", cyc, clk_en, e.en);
      end
      n_tests++;
      if (cfg_pend !== e.pend) begin
        n_fail++;
        $display("FAIL cfg_pend cyc=%0d got=%b exp=%b", cyc, cfg_pend, e.pend);
      end
      n_tests++;
      if (tick_cnt !== e.tick) begin
        n_fail++;
        $display("FAIL tick_cnt cyc=%0d got=%h exp=%h", cyc, tick_cnt, e.tick);
      end
    end
  end

  initial begin
    m_reset();
    step(0, 0, 0, 0, 0, '0, 1, 0);
    step(0, 0, 0, 0, 0, '0, 1, 0);
    step(0, 0, 0, 0, 0, '0, 1, 1);
    // ch0 D=3 continuous
    idle(7);
    wrc(0, 3, 1);
    idle(14);
    // ch1 D=4, retuned to D=1 mid-period
    wrc(1, 4, 1);
    idle(3);
    wrc(1, 1, 1);
    idle(12);
    // ch2 one-shot D=2
    wrc(2, 2, 2);
    idle(8);
    // sync on a ch0 terminal cycle
    wrc(0, 0, 0);
    wrc(1, 0, 0);
    wrc(0, 2, 1);
    wrc(1, 5, 1);
    idle(1);
    step(0, 0, 0, 0, 1, '0, 0, 1);
    idle(10);
    // tick wrap and clear-vs-strobe
    wrc(2, 0, 1);
    idle(17);
    step(0, 0, 0, 0, 0, 3'b100, 0, 1);
    idle(3);
    // invalid channel, stop a channel, mid-period reset with pending config
    step(1, 3, 1, 1, 0, '0, 0, 1);
    step(1, 3, 0, 0, 0, '0, 0, 1);
    wrc(2, 5, 3);
    idle(3);
    wrc(0, 6, 1);
    idle(2);
    step(0, 0, 0, 0, 0, '0, 1, 1);
    idle(4);
    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      bit [NCH-1:0] clr;
      for (int c = 0; c < NCH; c++) clr[c] = ($urandom_range(0, 19) == 0);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 3), $urandom_range(0, 6),
           $urandom_range(0, 3), $urandom_range(0, 31) == 0, clr,
           $urandom_range(0, 199) == 0, 1);
    end
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
